// File: rtl/dmem_host_loader_if.sv
// dmem_host_loader_if: host-side load and result byte streams
interface dmem_host_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/dmem_host_loader.sv
// dmem_host_loader: loads data memory, runs the core, then drains the result window
module dmem_host_loader #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    dmem_host_loader_if.slave host,
    output logic              mem_wen,
    output logic [7:0]        mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              core_reset,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              seq_done,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
    localparam logic [7:0]  LOAD_LAST = 8'(LOAD_LEN - 1);
    localparam logic [7:0]  RES_LAST  = 8'(RES_LEN - 1);
    localparam logic [15:0] RUN_LAST  = 16'(TIMEOUT - 1);
    state_t      state;
    logic [7:0]  idx;
    logic [15:0] cnt;
    logic        xfer;
    assign xfer           = host.out_valid && host.out_ready;
    assign busy           = state != IDLE;
    assign core_start     = state == START;
    assign core_reset     = !(state == START || state == RUN);
    assign host.in_ready  = state == LOAD;
    assign host.out_valid = state == DRAIN;
    assign host.out_data  = state == DRAIN ? mem_rdata : 8'h00;
    assign mem_wen        = state == LOAD && host.in_valid;
    assign mem_wdata      = state == LOAD ? host.in_data : 8'h00;
    assign mem_addr       = state == LOAD  ? 8'(LOAD_BASE) + idx :
                            state == DRAIN ? 8'(RES_BASE) + idx : 8'h00;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    timeout_err <= 1'b0;
                    idx         <= '0;
                    state       <= LOAD_LEN == 0 ? START : LOAD;
                end
                LOAD: if (host.in_valid) begin
                    idx <= idx == LOAD_LAST ? 8'h00 : idx + 8'd1;
                    if (idx == LOAD_LAST) state <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                // completion wins over a timeout landing in the same cycle
                RUN: begin
                    cnt <= cnt + 16'd1;
                    if (core_done) state <= DRAIN;
                    else if (cnt == RUN_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                DRAIN: if (xfer) begin
                    idx <= idx == RES_LAST ? 8'h00 : idx + 8'd1;
                    if (idx == RES_LAST) begin
                        seq_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dmem_host_loader.sv
// tb_dmem_host_loader: scoreboard bench with a memory model and a fake core
module tb_dmem_host_loader;
    localparam int LB = 250, LL = 10, RB = 64, RL = 32, TO = 24;
    logic       clk = 0, reset = 0, go = 0, core_done = 0, core_fill = 0;
    logic       mem_wen, core_reset, core_start, busy, seq_done, timeout_err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];
    logic [7:0] res_buf [RL];
    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    logic        held_v = 0;
    logic [7:0]  held;
    int errors = 0, checks = 0, seq_cnt = 0, exp_seq = 0;

    dmem_host_loader_if bus();
    dmem_host_loader #(.LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .go(go), .host(bus.slave),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .core_start(core_start), .core_done(core_done),
        .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (core_fill) for (int i = 0; i < RL; i++) mem[8'(RB + i)] <= res_buf[i];
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: memory writes and result transfers against the queues
    always @(negedge clk) begin
        if (seq_done) seq_cnt++;
        if (mem_wen) begin
            check("wen_only_in_load", 16'(bus.in_ready), 16'd1);
            if (wq.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 16'hxxxx);
            else check("load_write", {mem_addr, mem_wdata}, wq.pop_front());
        end
        if (held_v && bus.out_valid) check("out_hold", 16'(bus.out_data), 16'(held));
        if (bus.out_valid && bus.out_ready) begin
            if (rq.size() == 0) check("unexpected_out", 16'(bus.out_data), 16'hxxxx);
            else check("out_byte", 16'(bus.out_data), 16'(rq.pop_front()));
        end
        held_v = bus.out_valid && !bus.out_ready;
        held   = bus.out_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq;
        go = 1;
        tick;
        go = 0;
    endtask

    // k-th accepted byte of a sequence must land at LOAD_BASE+k modulo 256
    task automatic load(int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 0;
                tick;
            end
            bus.in_valid = 1;
            bus.in_data  = 8'($urandom);
            wq.push_back({8'((LB + k) % 256), bus.in_data});
            tick;
        end
        bus.in_valid = 0;
    endtask

    task automatic check_start;
        check("core_start_pulse", 16'(core_start), 16'd1);
        check("core_reset_start", 16'(core_reset), 16'd0);
    endtask

    // fake core: writes a fresh result window, then raises done after done_at cycles
    task automatic run_core(int done_at);
        tick;
        check("core_start_once", 16'(core_start), 16'd0);
        check("run_addr", 16'(mem_addr), 16'd0);
        for (int i = 0; i < RL; i++) begin
            res_buf[i] = 8'($urandom);
            rq.push_back(res_buf[i]);
        end
        core_fill = 1;
        tick;
        core_fill = 0;
        repeat (done_at - 2) tick;
        core_done = 1;
        tick;
        core_done = 0;
        check("drain_valid", 16'(bus.out_valid), 16'd1);
        check("drain_core_reset", 16'(core_reset), 16'd1);
    endtask

    task automatic drain(bit bp);
        int n = 0, cyc = 0, stall = 0;
        logic x;
        while (n < RL && cyc < 2000) begin
            if (bp && n == 3 && stall < 5) begin
                bus.out_ready = 0;
                stall++;
                @(negedge clk);
                check("bp_hold_mem67", 16'(bus.out_data), 16'(res_buf[3]));
            end else begin
                bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
            end
            x = bus.out_valid && bus.out_ready;
            tick;
            if (x) n++;
            cyc++;
        end
        bus.out_ready = 0;
        exp_seq++;
        check("drain_count", 16'(n), 16'(RL));
        check("seq_done_pulse", 16'(seq_done), 16'd1);
        check("idle_after_drain", 16'(busy), 16'd0);
        tick;
        check("seq_done_single", 16'(seq_done), 16'd0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.out_ready = 0;
        #1 reset = 1;
        #1;
        check("rst_core_reset", 16'(core_reset), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_timeout_err", 16'(timeout_err), 16'd0);
        check("rst_outputs", {core_start, seq_done, mem_wen, 5'd0, mem_addr}, 16'd0);
        repeat (2) @(posedge clk);
        #2 reset = 0;
        tick;
        // abort part-way through a load
        start_seq;
        check("load_in_ready", 16'(bus.in_ready), 16'd1);
        load(6);
        #2 reset = 1;
        #1;
        check("midrst_core_reset", 16'(core_reset), 16'd1);
        check("midrst_in_ready", 16'(bus.in_ready), 16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        @(posedge clk);
        #2 reset = 0;
        tick;
        // full sequence with done 20 cycles after start and drain backpressure
        start_seq;
        load(LL);
        check_start;
        run_core(20);
        check("drain_first_addr", 16'(mem_addr), 16'(RB));
        drain(1);
        // timeout run: core_done never arrives
        start_seq;
        load(LL);
        check_start;
        for (int i = 1; i <= TO + 1; i++) begin
            tick;
            if (i == TO) check("run_busy_last", {15'd0, busy}, 16'd1);
            if (i == TO) check("no_early_timeout", 16'(timeout_err), 16'd0);
        end
        check("timeout_idle", 16'(busy), 16'd0);
        check("timeout_err_set", 16'(timeout_err), 16'd1);
        repeat (3) tick;
        check("timeout_no_seq_done", 16'(seq_cnt), 16'(exp_seq));
        check("timeout_err_sticky", 16'(timeout_err), 16'd1);
        // next go clears the flag; done coincides with the timeout limit
        start_seq;
        check("go_clears_timeout", 16'(timeout_err), 16'd0);
        load(LL);
        check_start;
        run_core(TO);
        check("tie_no_timeout", 16'(timeout_err), 16'd0);
        drain(0);
        repeat (2) tick;
        check("write_queue_empty", 16'(wq.size()), 16'd0);
        check("result_queue_empty", 16'(rq.size()), 16'd0);
        check("seq_done_count", 16'(seq_cnt), 16'(exp_seq));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
